// File: rtl/fifo_pkg.sv
// Shared helpers for the write-arbitrated FIFO: circular pointer wrap and
// pointer/count width for a given slot count.
package fifo_pkg;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Wraps at depth, so any slot count works, not just powers of two.
    function automatic int unsigned next_ptr(input int unsigned p, input int unsigned depth);
        return (p + 1 == depth) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_arbiter.sv
// Single-winner request arbiter: round-robin starting at rr, or fixed lowest-index
// priority when FIFO_WR_ARB_FIXED_PRIO_EN is defined (rr is then ignored).
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   winner
);

    logic          found;
    logic [IW-1:0] idx;
    int            s;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^rr;
`endif

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        s      = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
            s = k;
`else
            s = int'(rr) + k;
            if (s >= NREQ) s = s - NREQ;
`endif
            idx = IW'(s);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                winner      = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Shared FIFO with NREQ arbitrated write ports and one show-ahead read port.
// Build option: FIFO_WR_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 5,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    input  logic                  rd,
    output logic [WIDTH-1:0]      rdata,
    output logic                  empty,
    output logic                  full,
    output logic [PW-1:0]         count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, count_q, count_d;
    logic [PW-1:0]    w_ptr_nx, r_ptr_nx;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [NREQ-1:0]  req_ok, arb_gnt;
    logic [IW-1:0]    winner, rr_sel;
    logic             wr_en, rd_en;
    logic [WIDTH-1:0] wr_data;

    assign w_ptr_nx = PW'(next_ptr(32'(w_ptr_q), DEPTH));
    assign r_ptr_nx = PW'(next_ptr(32'(r_ptr_q), DEPTH));

    assign empty = (w_ptr_q == r_ptr_q);
    assign full  = (w_ptr_nx == r_ptr_q);
    assign count = count_q;

    // Full comes from registered pointers, so a same-cycle pop never frees a slot early.
    assign req_ok = (rst || full) ? '0 : req;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req_ok),
        .rr     (rr_sel),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    assign gnt     = arb_gnt;
    assign wr_en   = |arb_gnt;
    assign rd_en   = rd && !empty && !rst;
    assign wr_data = wdata[winner*WIDTH +: WIDTH];
    assign rdata   = mem_q[r_ptr_q[AW-1:0]];

    always_comb begin
        w_ptr_d = wr_en ? w_ptr_nx : w_ptr_q;
        r_ptr_d = rd_en ? r_ptr_nx : r_ptr_q;
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[w_ptr_q[AW-1:0]] <= wr_data;
    end

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    logic unused_winner;
    assign unused_winner = ^winner;
    assign rr_sel        = '0;
`else
    logic [IW-1:0] rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (wr_en) rr_d = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end

    assign rr_sel = rr_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (NREQ=2, WIDTH=8, DEPTH=5).
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic        rd;
    logic [7:0]  rdata;
    logic        empty;
    logic        full;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    fifo_wr_arb #(.NREQ(2), .WIDTH(8), .DEPTH(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .rd    (rd),
        .rdata (rdata),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with requests and pops pending
        rst = 1'b1; req = 2'b11; rd = 1'b1; wdata = 16'h0000;
        tick();
        #1 chk("rst_gnt", 32'(gnt), 32'h0);
        tick();
        rst = 1'b0; req = 2'b00; rd = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full",  32'(full),  32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_gnt_rel", 32'(gnt), 32'h0);

        // Fill from requester 0: A1..A4
        for (int i = 0; i < 4; i++) begin
            req = 2'b01; wdata = {8'h00, 8'hA1 + 8'(i)};
            #1 chk("fill_gnt", 32'(gnt), 32'h1);
            tick();
        end
        req = 2'b01; wdata = 16'h00A5;
        #1;
        chk("fill_full",  32'(full),  32'h1);
        chk("fill_count", 32'(count), 32'h4);
        chk("fill_held",  32'(gnt),   32'h0);
        chk("fill_head",  32'(rdata), 32'hA1);
        tick();
        chk("held_gnt",   32'(gnt),   32'h0);
        chk("held_count", 32'(count), 32'h4);

        // Pop while full: write still blocked this cycle
        rd = 1'b1;
        #1 chk("fullrd_gnt", 32'(gnt), 32'h0);
        tick();
        rd = 1'b0;
        #1;
        chk("fullrd_count", 32'(count), 32'h3);
        chk("fullrd_full",  32'(full),  32'h0);
        chk("fullrd_head",  32'(rdata), 32'hA2);
        chk("a5_gnt",       32'(gnt),   32'h1);
        tick();
        req = 2'b00;
        #1;
        chk("a5_full",  32'(full),  32'h1);
        chk("a5_count", 32'(count), 32'h4);

        // Drain across the pointer wrap
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("drain_data", 32'(rdata), 32'(8'hA2 + 8'(i)));
            tick();
        end
        rd = 1'b0;
        #1;
        chk("drain_empty", 32'(empty), 32'h1);
        chk("drain_count", 32'(count), 32'h0);

        // Read on empty with concurrent write from requester 1
        rd = 1'b1; req = 2'b10; wdata = 16'h5C00;
        #1 chk("emp_gnt", 32'(gnt), 32'h2);
        tick();
        req = 2'b00; rd = 1'b0;
        #1;
        chk("emp_count", 32'(count), 32'h1);
        chk("emp_data",  32'(rdata), 32'h5C);
        chk("emp_flag",  32'(empty), 32'h0);
        rd = 1'b1;
        tick();
        tick();
        rd = 1'b0;
        #1;
        chk("underflow_count", 32'(count), 32'h0);
        chk("underflow_empty", 32'(empty), 32'h1);
        chk("underflow_full",  32'(full),  32'h0);

        // Reset mid-operation discards contents
        req = 2'b01; wdata = 16'h00A7;
        tick();
        req = 2'b00;
        #1 chk("mid_count", 32'(count), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'h1);
        chk("mid_rst_count", 32'(count), 32'h0);

`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
        // Round-robin with continuous pops
        req = 2'b11; rd = 1'b1; wdata = {8'hB0, 8'hA0};
        #1 chk("rr_gnt0", 32'(gnt), 32'h1);
        tick();
        wdata = {8'hB0, 8'hA1};
        #1;
        chk("rr_gnt1", 32'(gnt),   32'h2);
        chk("rr_out0", 32'(rdata), 32'hA0);
        tick();
        wdata = {8'hB1, 8'hA1};
        #1;
        chk("rr_gnt2", 32'(gnt),   32'h1);
        chk("rr_out1", 32'(rdata), 32'hB0);
        tick();
        wdata = {8'hB1, 8'hA2};
        #1;
        chk("rr_gnt3", 32'(gnt),   32'h2);
        chk("rr_out2", 32'(rdata), 32'hA1);
        tick();
        req = 2'b00;
        #1;
        chk("rr_out3",  32'(rdata), 32'hB1);
        chk("rr_count", 32'(count), 32'h1);
        tick();
        rd = 1'b0;
        #1 chk("rr_empty", 32'(empty), 32'h1);
`else
        // Fixed priority: requester 0 wins every slot until full
        req = 2'b11; rd = 1'b0; wdata = {8'hB0, 8'hA0};
        for (int i = 0; i < 4; i++) begin
            #1 chk("fp_gnt", 32'(gnt), 32'h1);
            tick();
        end
        #1;
        chk("fp_full_gnt", 32'(gnt),   32'h0);
        chk("fp_full",     32'(full),  32'h1);
        chk("fp_count",    32'(count), 32'h4);
        req = 2'b00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
